// File: rtl/hs_stream_upsizer.sv
// Packs RATIO narrow FWFT words (fewer when a word carries last) into one registered wide word.
// Wide word is valid the cycle after the closing narrow word is read; a closing word waits in the FIFO while the output slot is full.
module hs_stream_upsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int CNT_WIDTH  = $clog2(RATIO + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_empty_n,
  output logic                        in_read,
  input  logic [DATA_WIDTH:0]         in_dout,
  output logic                        if_empty_n,
  input  logic                        if_read,
  output logic [RATIO*DATA_WIDTH-1:0] if_dout,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        out_last
);
  localparam int IDX_WIDTH = $clog2(RATIO);
  localparam int WIDE      = RATIO * DATA_WIDTH;

  logic [IDX_WIDTH-1:0]  idx;
  logic [WIDE-1:0]       acc;
  logic [WIDE-1:0]       merged;
  logic [DATA_WIDTH-1:0] in_payload;
  logic                  in_last;
  logic                  slot_free;
  logic                  closing;
  logic                  fill;
  logic                  close;

  assign in_payload = in_dout[DATA_WIDTH-1:0];
  assign in_last    = in_dout[DATA_WIDTH];

  // Only a closing word needs the output slot; open lanes keep filling while the output is held.
  assign slot_free = !if_empty_n || if_read;
  assign closing   = (idx == IDX_WIDTH'(RATIO - 1)) || in_last;
  assign in_read   = reset_n && in_empty_n && (!closing || slot_free);
  assign fill      = in_read && !closing;
  assign close     = in_read && closing;

  always_comb begin
    merged = acc;
    merged[idx*DATA_WIDTH +: DATA_WIDTH] = in_payload;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
      acc <= '0;
    end else if (close) begin
      idx <= '0;
      acc <= '0;
    end else if (fill) begin
      idx <= idx + IDX_WIDTH'(1);
      acc <= merged;
    end
  end

  // A close in the same cycle as a drain overwrites the slot, so valid never drops between words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_empty_n <= 1'b0;
      if_dout    <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end else if (close) begin
      if_empty_n <= 1'b1;
      if_dout    <= merged;
      out_count  <= CNT_WIDTH'(idx) + CNT_WIDTH'(1);
      out_last   <= in_last;
    end else if (if_read && if_empty_n) begin
      if_empty_n <= 1'b0;
    end
  end

endmodule
